hpi_bus_arbiter: RTL and testbench

HPI_BUS_ARBITER -- requirements
Module: hpi_bus_arbiter

---
 rtl/hpi_arb_pkg.sv | 23 ++
 rtl/hpi_rr_grant.sv | 19 +
 rtl/hpi_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_hpi_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpi_arb_pkg.sv
// Shared types and timing defaults for the HPI bus arbiter.
// Imported by the arbiter top and its testbench-facing users.
package hpi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_ACK
    } hpi_arb_state_t;

    localparam int DEF_STROBE_CYC = 4;
    localparam int DEF_HOLD_CYC   = 2;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    function automatic logic [3:0] cnt_init(input int cyc);
        return 4'(cyc - 1);
    endfunction

endpackage

// File: rtl/hpi_rr_grant.sv
// Two-way round-robin grant: a tie goes to the requester not served last.
// Bit 0 is requester A, bit 1 is requester B; last = 1 means B was served last.
module hpi_rr_grant (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/hpi_bus_arbiter.sv
// Arbitrates two requesters onto one HPI port and sequences the pin timing:
// SETUP, STROBE_CYC strobe cycles, HOLD_CYC hold cycles, then an ack pulse.
module hpi_bus_arbiter
    import hpi_arb_pkg::*;
#(
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [1:0]  a_addr,
    input  logic [15:0] a_wdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [1:0]  b_addr,
    input  logic [15:0] b_wdata,
    output logic        a_ack,
    output logic        b_ack,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [15:0] otg_dout,
    output logic        otg_oe,
    input  logic [15:0] otg_din
);

    localparam logic [3:0] STRB_INIT = cnt_init(STROBE_CYC);
    localparam logic [3:0] HOLD_INIT = cnt_init(HOLD_CYC);

    hpi_arb_state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [1:0]  gnt;
    logic        start;
    logic        last_gnt;
    logic        lat_own;
    logic        lat_we;
    logic [1:0]  lat_addr;
    logic [15:0] lat_wdata;
    logic        active;
    logic        rd_last;

    hpi_rr_grant u_grant (
        .req  ({b_req, a_req}),
        .last (last_gnt),
        .gnt  (gnt)
    );

    assign start   = (state == ST_IDLE) && (|gnt);
    assign rd_last = (state == ST_STROBE) && (cnt == 4'd0) && !lat_we;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (start)
                    state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                state_nxt = ST_STROBE;
                cnt_nxt   = STRB_INIT;
            end
            ST_STROBE: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = HOLD_INIT;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt == 4'd0)
                    state_nxt = ST_ACK;
                else
                    cnt_nxt = cnt - 4'd1;
            end
            ST_ACK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            last_gnt  <= OWN_B;
            lat_own   <= OWN_A;
            lat_we    <= 1'b0;
            lat_addr  <= 2'd0;
            lat_wdata <= 16'd0;
            rdata     <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start) begin
                last_gnt  <= gnt[1];
                lat_own   <= gnt[1];
                lat_we    <= gnt[1] ? b_we    : a_we;
                lat_addr  <= gnt[1] ? b_addr  : a_addr;
                lat_wdata <= gnt[1] ? b_wdata : a_wdata;
            end
            if (rd_last)
                rdata <= otg_din;
        end
    end

    // Pin controls decode straight from state so reset releases them at once.
    assign active   = (state == ST_SETUP) || (state == ST_STROBE) ||
                      (state == ST_HOLD);
    assign busy     = (state != ST_IDLE);
    assign otg_cs_n = !active;
    assign otg_addr = active ? lat_addr : 2'd0;
    assign otg_rd_n = !((state == ST_STROBE) && !lat_we);
    assign otg_wr_n = !((state == ST_STROBE) && lat_we);
    assign otg_oe   = active && lat_we;
    assign otg_dout = otg_oe ? lat_wdata : 16'd0;
    assign a_ack    = (state == ST_ACK) && (lat_own == OWN_A);
    assign b_ack    = (state == ST_ACK) && (lat_own == OWN_B);

endmodule

// File: tb/tb_hpi_bus_arbiter.sv
// Self-checking bench for hpi_bus_arbiter: vector table, corner sequences,
// and randomized traffic against a transaction-timeline reference model.
module tb_hpi_bus_arbiter;

    localparam int S = 4;
    localparam int H = 2;
    localparam int N = 2 + S + H;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        a_req, b_req, a_we, b_we;
    logic [1:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata, otg_din;

    logic        a_ack, b_ack, busy, otg_cs_n, otg_rd_n, otg_wr_n, otg_oe;
    logic [15:0] rdata, otg_dout;
    logic [1:0]  otg_addr;

    logic        a_ack2, b_ack2, busy2, cs_n2, rd_n2, wr_n2, oe2;
    logic [15:0] rdata2, dout2;
    logic [1:0]  addr2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    hpi_bus_arbiter #(.STROBE_CYC(S), .HOLD_CYC(H)) dut (
        .Clk(Clk), .Reset(Reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_ack(a_ack), .b_ack(b_ack), .rdata(rdata), .busy(busy),
        .otg_addr(otg_addr), .otg_cs_n(otg_cs_n), .otg_rd_n(otg_rd_n),
        .otg_wr_n(otg_wr_n), .otg_dout(otg_dout), .otg_oe(otg_oe),
        .otg_din(otg_din)
    );

    hpi_bus_arbiter #(.STROBE_CYC(1), .HOLD_CYC(1)) dut2 (
        .Clk(Clk), .Reset(Reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_ack(a_ack2), .b_ack(b_ack2), .rdata(rdata2), .busy(busy2),
        .otg_addr(addr2), .otg_cs_n(cs_n2), .otg_rd_n(rd_n2),
        .otg_wr_n(wr_n2), .otg_dout(dout2), .otg_oe(oe2),
        .otg_din(otg_din)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        a_req, b_req, a_we, b_we;
        logic [1:0]  a_addr, b_addr;
        logic [15:0] a_wd, b_wd, din;
        logic        exp_b;
        logic        exp_we;
        logic [1:0]  exp_addr;
        logic [15:0] exp_dout;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    // Reference model state: a transaction is a timeline index t = 1..N.
    logic        m_active, m_own, m_we, m_last;
    int          m_t;
    logic [1:0]  m_addr;
    logic [15:0] m_wd, m_rdata;

    task automatic model_step();
        if (Reset) begin
            m_active = 1'b0;
            m_last   = 1'b1;
            m_rdata  = 16'd0;
        end else if (m_active) begin
            if (!m_we && m_t == 1 + S)
                m_rdata = otg_din;
            if (m_t == N) m_active = 1'b0;
            else m_t++;
        end else if (a_req || b_req) begin
            m_own    = (a_req && b_req) ? !m_last : b_req;
            m_last   = m_own;
            m_we     = m_own ? b_we : a_we;
            m_addr   = m_own ? b_addr : a_addr;
            m_wd     = m_own ? b_wdata : a_wdata;
            m_t      = 1;
            m_active = 1'b1;
        end
    endtask

    task automatic model_check();
        logic ph, strb;
        ph   = m_active && m_t <= 1 + S + H;
        strb = m_active && m_t >= 2 && m_t <= 1 + S;
        check("rnd_busy", busy, m_active);
        check("rnd_cs_n", otg_cs_n, !ph);
        check("rnd_rd_n", otg_rd_n, !(strb && !m_we));
        check("rnd_wr_n", otg_wr_n, !(strb && m_we));
        check("rnd_oe", otg_oe, ph && m_we);
        check("rnd_dout", otg_dout, (ph && m_we) ? m_wd : 16'd0);
        check("rnd_addr", otg_addr, ph ? m_addr : 2'd0);
        check("rnd_a_ack", a_ack, m_active && m_t == N && !m_own);
        check("rnd_b_ack", b_ack, m_active && m_t == N && m_own);
        check("rnd_rdata", rdata, m_rdata);
    endtask

    task automatic idle_inputs();
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
    endtask

    initial begin
        int a_first, a_cnt, b_first, b_cnt;
        int rd_low, wr_low, rd_first, wr_first, oe_cnt, cs_cnt;
        int a2_first, a2_cnt, rd2_low;
        logic [1:0]  addr_c3;
        logic [15:0] dout_c3;
        int ev_cyc[$];
        logic ev_who[$];

        vecs[0] = '{1,0,0,0, 2'd2,2'd0, 16'h0000,16'h0000, 16'hBEEF,
                    0,0,2'd2,16'h0000,16'hBEEF};
        vecs[1] = '{0,1,0,1, 2'd0,2'd1, 16'h0000,16'h1234, 16'h7777,
                    1,1,2'd1,16'h1234,16'hBEEF};
        vecs[2] = '{1,1,0,1, 2'd3,2'd0, 16'h0000,16'h5555, 16'h5A5A,
                    0,0,2'd3,16'h0000,16'h5A5A};
        vecs[3] = '{1,1,1,0, 2'd2,2'd1, 16'h1111,16'h0000, 16'hC3C3,
                    1,0,2'd1,16'h0000,16'hC3C3};
        vecs[4] = '{1,1,1,0, 2'd0,2'd2, 16'hABCD,16'h0000, 16'h0000,
                    0,1,2'd0,16'hABCD,16'hC3C3};
        vecs[5] = '{1,0,1,0, 2'd3,2'd0, 16'hFFFF,16'h0000, 16'h9999,
                    0,1,2'd3,16'hFFFF,16'hC3C3};
        vecs[6] = '{0,1,0,0, 2'd0,2'd0, 16'h0000,16'h0000, 16'h8001,
                    1,0,2'd0,16'h0000,16'h8001};

        idle_inputs();
        otg_din = 16'h0;
        Reset   = 1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_cs_n", otg_cs_n, 1);
        check("rst_rd_n", otg_rd_n, 1);
        check("rst_wr_n", otg_wr_n, 1);
        check("rst_oe", otg_oe, 0);
        check("rst_addr", otg_addr, 0);
        check("rst_dout", otg_dout, 0);
        check("rst_acks", {a_ack, b_ack}, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 0);
        @(posedge Clk); #1 Reset = 0;

        for (int i = 0; i < 7; i++) begin
            @(posedge Clk); #1;
            a_req = vecs[i].a_req; b_req = vecs[i].b_req;
            a_we = vecs[i].a_we; b_we = vecs[i].b_we;
            a_addr = vecs[i].a_addr; b_addr = vecs[i].b_addr;
            a_wdata = vecs[i].a_wd; b_wdata = vecs[i].b_wd;
            otg_din = vecs[i].din;
            a_first = 0; a_cnt = 0; b_first = 0; b_cnt = 0;
            rd_low = 0; wr_low = 0; rd_first = 0; wr_first = 0;
            oe_cnt = 0; cs_cnt = 0; a2_first = 0; a2_cnt = 0; rd2_low = 0;
            addr_c3 = 0; dout_c3 = 0;
            for (int k = 1; k <= 9; k++) begin
                @(posedge Clk); #1;
                if (k == 3) begin a_req = 0; b_req = 0; end
                @(negedge Clk);
                if (a_ack) begin a_cnt++; if (a_first == 0) a_first = k; end
                if (b_ack) begin b_cnt++; if (b_first == 0) b_first = k; end
                if (!otg_rd_n) begin rd_low++; if (rd_first == 0) rd_first = k; end
                if (!otg_wr_n) begin wr_low++; if (wr_first == 0) wr_first = k; end
                if (otg_oe) oe_cnt++;
                if (!otg_cs_n) cs_cnt++;
                if (a_ack2) begin a2_cnt++; if (a2_first == 0) a2_first = k; end
                if (!rd_n2) rd2_low++;
                if (k == 3) begin addr_c3 = otg_addr; dout_c3 = otg_dout; end
            end
            check($sformatf("v%0d_ack_cyc", i),
                  vecs[i].exp_b ? b_first : a_first, N);
            check($sformatf("v%0d_ack_cnt", i),
                  vecs[i].exp_b ? b_cnt : a_cnt, 1);
            check($sformatf("v%0d_other_ack", i),
                  vecs[i].exp_b ? a_cnt : b_cnt, 0);
            check($sformatf("v%0d_rd_low", i), rd_low, vecs[i].exp_we ? 0 : S);
            check($sformatf("v%0d_wr_low", i), wr_low, vecs[i].exp_we ? S : 0);
            check($sformatf("v%0d_strb_start", i),
                  vecs[i].exp_we ? wr_first : rd_first, 2);
            check($sformatf("v%0d_oe_cnt", i), oe_cnt,
                  vecs[i].exp_we ? 1 + S + H : 0);
            check($sformatf("v%0d_cs_cnt", i), cs_cnt, 1 + S + H);
            check($sformatf("v%0d_addr", i), addr_c3, vecs[i].exp_addr);
            check($sformatf("v%0d_dout", i), dout_c3, vecs[i].exp_dout);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            if (i == 0) begin
                check("p11_ack_cyc", a2_first, 4);
                check("p11_ack_cnt", a2_cnt, 1);
                check("p11_rd_low", rd2_low, 1);
                check("p11_rdata", rdata2, 16'hBEEF);
            end
        end

        // Reset in cycle 3 of a B write aborts it without an ack.
        @(posedge Clk); #1;
        idle_inputs();
        b_req = 1; b_we = 1; b_addr = 1; b_wdata = 16'h4242;
        b_cnt = 0; a_cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge Clk); #1;
            if (k == 3) begin Reset = 1; b_req = 0; end
            if (k == 4) Reset = 0;
            @(negedge Clk);
            if (k == 3) check("abort_pre_wr_n", otg_wr_n, 0);
            if (k == 4) begin
                check("abort_cs_n", otg_cs_n, 1);
                check("abort_wr_n", otg_wr_n, 1);
                check("abort_oe", otg_oe, 0);
                check("abort_busy", busy, 0);
            end
            if (a_ack) a_cnt++;
            if (b_ack) b_cnt++;
        end
        check("abort_no_ack", a_cnt + b_cnt, 0);

        // Both requests held from reset: A, B, A, B with 9-cycle spacing.
        @(posedge Clk); #1;
        a_req = 1; b_req = 1; a_we = 0; b_we = 1;
        a_addr = 0; b_addr = 3; b_wdata = 16'h0F0F;
        for (int k = 1; k <= 40; k++) begin
            @(posedge Clk); #1;
            @(negedge Clk);
            if (a_ack) begin ev_cyc.push_back(k); ev_who.push_back(0); end
            if (b_ack) begin ev_cyc.push_back(k); ev_who.push_back(1); end
        end
        a_req = 0; b_req = 0;
        check("tie_n_events", ev_cyc.size(), 4);
        for (int j = 0; j < 4; j++) begin
            if (j < ev_cyc.size()) begin
                check($sformatf("tie_cyc%0d", j), ev_cyc[j], N + j * (N + 1));
                check($sformatf("tie_who%0d", j), ev_who[j], j % 2);
            end
        end
        repeat (12) @(posedge Clk);

        // Randomized traffic against the reference model.
        #1 Reset = 1;
        for (int c = 0; c < 1500; c++) begin
            @(posedge Clk);
            model_step();
            #1;
            Reset   = ($urandom_range(0, 99) == 0);
            a_req   = ($urandom_range(0, 9) < 4);
            b_req   = ($urandom_range(0, 9) < 4);
            a_we    = $urandom_range(0, 1);
            b_we    = $urandom_range(0, 1);
            a_addr  = 2'($urandom);
            b_addr  = 2'($urandom);
            a_wdata = 16'($urandom);
            b_wdata = 16'($urandom);
            otg_din = 16'($urandom);
            @(negedge Clk);
            if (c > 0) model_check();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
